// File: rtl/pe_filter_mac_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pe_pkg
//  Description : Shared types and constants for the processing-element
//                stages: FSM state encoding, default filter width and the
//                signed product-width helper.
//  Revision    : 1.0  initial release
// ============================================================================
package pe_pkg;

  // Top-level FSM of a filter MAC stage
  typedef enum logic [1:0] {
    LOAD_WT = 2'd0,
    MAC     = 2'd1,
    ADD     = 2'd2,
    OUT     = 2'd3
  } pe_state_e;

  localparam int c_FILTER_W_DEFAULT = 3;

  // An unsigned pixel widened by one sign bit times a signed weight
  // needs 2*DWIDTH+1 bits to hold every product exactly.
  function automatic int prod_width(input int dw);
    return 2 * dw + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pe_filter_mac_if.sv
`default_nettype none
// ============================================================================
//  Module      : pe_filter_mac_if
//  Description : Handshake bundle of the filter MAC stage.
//                Channels: weight load (wt_*), pixel stream (pix_*),
//                neighbour partial sum in (psum_in_*), result out
//                (psum_out_*), plus the completed-window counter.
//                master = stimulus/upstream side, slave = MAC stage.
//  Revision    : 1.0  initial release
// ============================================================================
interface pe_filter_mac_if #(
  parameter int DWIDTH = 8,
  parameter int PWIDTH = 24
);
  logic              wt_valid;
  logic              wt_ready;
  logic [DWIDTH-1:0] wt_data;
  logic              wt_reload;
  logic              pix_valid;
  logic              pix_ready;
  logic [DWIDTH-1:0] pix_data;
  logic              psum_in_valid;
  logic              psum_in_ready;
  logic [PWIDTH-1:0] psum_in_data;
  logic              psum_out_valid;
  logic              psum_out_ready;
  logic [PWIDTH-1:0] psum_out_data;
  logic [15:0]       win_cnt;

  modport master (
    output wt_valid, wt_data, wt_reload, pix_valid, pix_data,
           psum_in_valid, psum_in_data, psum_out_ready,
    input  wt_ready, pix_ready, psum_in_ready, psum_out_valid,
           psum_out_data, win_cnt
  );

  modport slave (
    input  wt_valid, wt_data, wt_reload, pix_valid, pix_data,
           psum_in_valid, psum_in_data, psum_out_ready,
    output wt_ready, pix_ready, psum_in_ready, psum_out_valid,
           psum_out_data, win_cnt
  );
endinterface
`default_nettype wire

// File: rtl/pe_filter_mac_dp.sv
`default_nettype none
// ============================================================================
//  Module      : pe_mac_dp
//  Description : Combinational multiply-add: acc_o = acc_i + sext(pix*wt).
//                Ports: pix_i (unsigned pixel), wt_i (signed weight),
//                acc_i (current accumulator), acc_o (next accumulator).
//                Sum wraps modulo 2^PWIDTH.
//  Revision    : 1.0  initial release
// ============================================================================
module pe_mac_dp
  import pe_pkg::*;
#(
  parameter int DWIDTH = 8,
  parameter int PWIDTH = 24
) (
  input  logic [DWIDTH-1:0] pix_i,
  input  logic [DWIDTH-1:0] wt_i,
  input  logic [PWIDTH-1:0] acc_i,
  output logic [PWIDTH-1:0] acc_o
);

  localparam int c_PW = prod_width(DWIDTH);

  logic signed [DWIDTH:0]   pix_s;
  logic signed [DWIDTH-1:0] wt_s;
  logic signed [c_PW-1:0]   prod;
  logic        [PWIDTH-1:0] prod_ext;

  // Zero-extend the pixel so it multiplies as a non-negative signed value
  assign pix_s = {1'b0, pix_i};
  assign wt_s  = wt_i;
  assign prod  = pix_s * wt_s;

  generate
    if (PWIDTH > c_PW) begin : g_sext
      assign prod_ext = {{(PWIDTH - c_PW){prod[c_PW-1]}}, prod};
    end else begin : g_trunc
      assign prod_ext = prod[PWIDTH-1:0];
    end
  endgenerate

  assign acc_o = acc_i + prod_ext;

endmodule
`default_nettype wire

// File: rtl/pe_filter_mac.sv
`default_nettype none
// ============================================================================
//  Module      : pe_filter_mac
//  Description : Per-PE 3-tap filter multiply-accumulate stage. Loads a
//                filter row, consumes one window of pixels, optionally adds
//                the neighbour partial sum and emits one result per window.
//                Ports: clk, rst_n (async, active-low),
//                       bus (pe_filter_mac_if.slave): weight, pixel,
//                       psum-in and psum-out handshakes plus win_cnt.
//  Revision    : 1.0  initial release
// ============================================================================
module pe_filter_mac
  import pe_pkg::*;
#(
  parameter int DWIDTH   = 8,
  parameter int PWIDTH   = 24,
  parameter int FILTER_W = c_FILTER_W_DEFAULT,
  parameter int ACCUM_IN = 0
) (
  input  logic           clk,
  input  logic           rst_n,
  pe_filter_mac_if.slave bus
);

  localparam int                c_TW   = (FILTER_W > 1) ? $clog2(FILTER_W) : 1;
  localparam logic [c_TW-1:0]   c_LAST = c_TW'(FILTER_W - 1);

  pe_state_e         state_q, state_d;
  logic [c_TW-1:0]   tap_q, tap_d;
  logic [PWIDTH-1:0] acc_q, acc_d;
  logic [15:0]       win_cnt_q, win_cnt_d;
  logic [DWIDTH-1:0] wt_q [FILTER_W];
  logic [DWIDTH-1:0] wt_d [FILTER_W];
  logic [PWIDTH-1:0] acc_mac;

  pe_mac_dp #(
    .DWIDTH (DWIDTH),
    .PWIDTH (PWIDTH)
  ) u_dp (
    .pix_i (bus.pix_data),
    .wt_i  (wt_q[tap_q]),
    .acc_i (acc_q),
    .acc_o (acc_mac)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= LOAD_WT;
      tap_q     <= '0;
      acc_q     <= '0;
      win_cnt_q <= '0;
      for (int i = 0; i < FILTER_W; i++) wt_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      tap_q     <= tap_d;
      acc_q     <= acc_d;
      win_cnt_q <= win_cnt_d;
      for (int i = 0; i < FILTER_W; i++) wt_q[i] <= wt_d[i];
    end
  end

  always_comb begin
    state_d   = state_q;
    tap_d     = tap_q;
    acc_d     = acc_q;
    win_cnt_d = win_cnt_q;
    for (int i = 0; i < FILTER_W; i++) wt_d[i] = wt_q[i];
    bus.wt_ready       = 1'b0;
    bus.pix_ready      = 1'b0;
    bus.psum_in_ready  = 1'b0;
    bus.psum_out_valid = 1'b0;

    case (state_q)
      LOAD_WT: begin
        // Reset parks the FSM here; keep ready low while reset is held
        bus.wt_ready = rst_n;
        if (bus.wt_valid) begin
          wt_d[tap_q] = bus.wt_data;
          if (tap_q == c_LAST) begin
            tap_d   = '0;
            acc_d   = '0;
            state_d = MAC;
          end else begin
            tap_d = tap_q + c_TW'(1);
          end
        end
      end
      MAC: begin
        // A reload at a window boundary wins over a pending pixel
        if (tap_q == '0 && bus.wt_reload) begin
          state_d = LOAD_WT;
        end else begin
          bus.pix_ready = 1'b1;
          if (bus.pix_valid) begin
            acc_d = acc_mac;
            if (tap_q == c_LAST) begin
              tap_d   = '0;
              state_d = (ACCUM_IN != 0) ? ADD : OUT;
            end else begin
              tap_d = tap_q + c_TW'(1);
            end
          end
        end
      end
      ADD: begin
        bus.psum_in_ready = 1'b1;
        if (bus.psum_in_valid) begin
          acc_d   = acc_q + bus.psum_in_data;
          state_d = OUT;
        end
      end
      OUT: begin
        bus.psum_out_valid = 1'b1;
        if (bus.psum_out_ready) begin
          win_cnt_d = win_cnt_q + 16'd1;
          acc_d     = '0;
          state_d   = MAC;
        end
      end
      default: state_d = LOAD_WT;
    endcase
  end

  // acc is only non-zero outside OUT while a window is being built; the
  // consumer qualifies it with psum_out_valid.
  assign bus.psum_out_data = acc_q;
  assign bus.win_cnt       = win_cnt_q;

endmodule
`default_nettype wire
